// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared state encodings and widths for the EX-stage divider
package div_unit_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_BUSY = 2'b01,
      DIV_ZERO = 2'b10,
      DIV_END  = 2'b11
   } div_state_e;

   localparam int DIV_WIDTH    = 32;
   localparam int DIV_RESULT_W = 2 * DIV_WIDTH;

   // ALU opcodes the EX stage decodes to select this unit.
   localparam logic [7:0] DIV_CONTROL  = 8'b0001_1010;
   localparam logic [7:0] DIVU_CONTROL = 8'b0001_1011;

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - restoring radix-2 DIV/DIVU, one quotient bit per cycle
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_div,
   input  logic [WIDTH-1:0]     opdata1,
   input  logic [WIDTH-1:0]     opdata2,
   input  logic                 annul,
   output logic [2*WIDTH-1:0]   result,
   output logic                 ready
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   div_state_e         state;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH:0]   work;
   logic [WIDTH-1:0]   divisor;
   logic               q_neg;
   logic               r_neg;

   logic               neg1;
   logic               neg2;
   logic [2*WIDTH:0]   shifted;
   logic [WIDTH+1:0]   trial;
   logic [2*WIDTH:0]   next_work;

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? ({WIDTH{1'b0}} - v) : v;
   endfunction

   assign neg1 = signed_div & opdata1[WIDTH-1];
   assign neg2 = signed_div & opdata2[WIDTH-1];

   // Upper half holds the partial remainder, lower half collects quotient bits.
   always_comb begin
      shifted   = {work[2*WIDTH-1:0], 1'b0};
      trial     = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, divisor};
      next_work = shifted;
      if (!trial[WIDTH+1])
         next_work = {trial[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= DIV_IDLE;
         cnt     <= '0;
         work    <= '0;
         divisor <= '0;
         q_neg   <= 1'b0;
         r_neg   <= 1'b0;
         result  <= '0;
         ready   <= 1'b0;
      end else begin
         ready <= 1'b0;
         case (state)
            DIV_IDLE: begin
               if (start && !annul) begin
                  q_neg   <= neg1 ^ neg2;
                  r_neg   <= neg1;
                  divisor <= cond_neg(opdata2, neg2);
                  work    <= {{(WIDTH+1){1'b0}}, cond_neg(opdata1, neg1)};
                  cnt     <= '0;
                  state   <= (opdata2 == '0) ? DIV_ZERO : DIV_BUSY;
               end
            end
            DIV_BUSY: begin
               if (!start || annul) begin
                  state <= DIV_IDLE;
                  cnt   <= '0;
               end else begin
                  work <= next_work;
                  cnt  <= cnt + CNT_W'(1);
                  if (cnt == LAST_CNT) begin
                     result <= {cond_neg(next_work[2*WIDTH-1:WIDTH], r_neg),
                                cond_neg(next_work[WIDTH-1:0], q_neg)};
                     ready  <= 1'b1;
                     state  <= DIV_END;
                  end
               end
            end
            DIV_ZERO: begin
               result <= '0;
               ready  <= 1'b1;
               state  <= DIV_END;
            end
            DIV_END: begin
               state <= DIV_IDLE;
            end
            default: state <= DIV_IDLE;
         endcase
      end
   end

endmodule
